id_stage: RTL and testbench



---
 rtl/id_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: IF/ID register, register-file read, write-back bypass, decode and ID/EX register.
// Ports: fetch handshake (if_*/id_ready), flush, rf read/write-back taps, ex_* ID/EX outputs with ex_ready backpressure.
module id_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic        id_ready,
   input  logic        flush,
   output logic [4:0]  rf_addr1,
   output logic [4:0]  rf_addr2,
   input  logic [31:0] rf_data1,
   input  logic [31:0] rf_data2,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        ex_ready,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_op1,
   output logic [31:0] ex_op2,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_dest,
   output logic [4:0]  ex_shamt,
   output logic [3:0]  ex_alu_op,
   output logic        ex_alu_src_imm,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_illegal,
   output logic [1:0]  ex_branch
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sh;
   logic [15:0] imm16;

   assign opcode = id_instr[31:26];
   assign rs     = id_instr[25:21];
   assign rt     = id_instr[20:16];
   assign rd     = id_instr[15:11];
   assign sh     = id_instr[10:6];
   assign funct  = id_instr[5:0];
   assign imm16  = id_instr[15:0];

   assign rf_addr1 = rs;
   assign rf_addr2 = rt;

   logic [3:0]  d_alu;
   logic        d_src;
   logic        d_rw;
   logic        d_mr;
   logic        d_mw;
   logic        d_ill;
   logic [1:0]  d_br;
   logic [4:0]  d_dest;
   logic [4:0]  d_shamt;
   logic [31:0] d_imm;
   logic        rt_used;
   logic [31:0] sext;
   logic [31:0] zext;

   assign sext = {{16{imm16[15]}}, imm16};
   assign zext = {16'h0, imm16};

   always_comb begin
      d_alu   = ALU_ADD;
      d_src   = 1'b0;
      d_rw    = 1'b0;
      d_mr    = 1'b0;
      d_mw    = 1'b0;
      d_ill   = 1'b0;
      d_br    = 2'b00;
      d_dest  = rt;
      d_shamt = 5'd0;
      d_imm   = sext;
      rt_used = 1'b0;
      unique case (1'b1)
         (opcode == 6'h00): begin
            d_dest  = rd;
            d_rw    = 1'b1;
            d_imm   = 32'h0;
            rt_used = 1'b1;
            unique case (1'b1)
               (funct == 6'h20),
               (funct == 6'h21): d_alu = ALU_ADD;
               (funct == 6'h22),
               (funct == 6'h23): d_alu = ALU_SUB;
               (funct == 6'h24): d_alu = ALU_AND;
               (funct == 6'h25): d_alu = ALU_OR;
               (funct == 6'h26): d_alu = ALU_XOR;
               (funct == 6'h27): d_alu = ALU_NOR;
               (funct == 6'h2A): d_alu = ALU_SLT;
               (funct == 6'h2B): d_alu = ALU_SLTU;
               (funct == 6'h00): begin
                  d_alu   = ALU_SLL;
                  d_shamt = sh;
               end
               (funct == 6'h02): begin
                  d_alu   = ALU_SRL;
                  d_shamt = sh;
               end
               (funct == 6'h03): begin
                  d_alu   = ALU_SRA;
                  d_shamt = sh;
               end
               default: begin
                  d_rw  = 1'b0;
                  d_ill = 1'b1;
               end
            endcase
         end
         (opcode == 6'h08),
         (opcode == 6'h09): begin
            d_src = 1'b1;
            d_rw  = 1'b1;
         end
         (opcode == 6'h0A): begin
            d_alu = ALU_SLT;
            d_src = 1'b1;
            d_rw  = 1'b1;
         end
         (opcode == 6'h23): begin
            d_src = 1'b1;
            d_rw  = 1'b1;
            d_mr  = 1'b1;
         end
         (opcode == 6'h2B): begin
            d_src   = 1'b1;
            d_mw    = 1'b1;
            rt_used = 1'b1;
         end
         (opcode == 6'h0C): begin
            d_alu = ALU_AND;
            d_src = 1'b1;
            d_rw  = 1'b1;
            d_imm = zext;
         end
         (opcode == 6'h0D): begin
            d_alu = ALU_OR;
            d_src = 1'b1;
            d_rw  = 1'b1;
            d_imm = zext;
         end
         (opcode == 6'h0E): begin
            d_alu = ALU_XOR;
            d_src = 1'b1;
            d_rw  = 1'b1;
            d_imm = zext;
         end
         (opcode == 6'h0F): begin
            d_alu = ALU_LUI;
            d_src = 1'b1;
            d_rw  = 1'b1;
            d_imm = {imm16, 16'h0};
         end
         (opcode == 6'h04): begin
            d_alu   = ALU_SUB;
            d_br    = 2'b01;
            rt_used = 1'b1;
         end
         (opcode == 6'h05): begin
            d_alu   = ALU_SUB;
            d_br    = 2'b10;
            rt_used = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
   end

   // $0 is never written, so a write to it is dropped here
   logic d_wr;
   assign d_wr = d_rw & (d_dest != 5'd0);

   // Register file write lands at the same edge, so forward it now
   logic [31:0] op1;
   logic [31:0] op2;
   assign op1 = (wb_reg_write && wb_addr != 5'd0 && wb_addr == rs) ? wb_data : rf_data1;
   assign op2 = (wb_reg_write && wb_addr != 5'd0 && wb_addr == rt) ? wb_data : rf_data2;

   logic hazard;
   logic ex_free;
   logic advance;
   assign hazard = id_valid & ex_valid & ex_mem_read & (ex_dest != 5'd0) &
                   ((ex_dest == rs) | (rt_used & (ex_dest == rt)));
   assign ex_free  = !ex_valid | ex_ready;
   assign advance  = id_valid & !hazard & ex_free;
   assign id_ready = !id_valid | advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid       <= 1'b0;
         id_instr       <= 32'h0;
         id_pc          <= 32'h0;
         ex_valid       <= 1'b0;
         ex_pc          <= 32'h0;
         ex_op1         <= 32'h0;
         ex_op2         <= 32'h0;
         ex_imm         <= 32'h0;
         ex_dest        <= 5'd0;
         ex_shamt       <= 5'd0;
         ex_alu_op      <= 4'd0;
         ex_alu_src_imm <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_illegal     <= 1'b0;
         ex_branch      <= 2'b00;
      end else if (flush) begin
         id_valid <= 1'b0;
         ex_valid <= 1'b0;
      end else begin
         if (advance) begin
            ex_valid       <= 1'b1;
            ex_pc          <= id_pc;
            ex_op1         <= op1;
            ex_op2         <= op2;
            ex_imm         <= d_imm;
            ex_dest        <= d_dest;
            ex_shamt       <= d_shamt;
            ex_alu_op      <= d_alu;
            ex_alu_src_imm <= d_src;
            ex_reg_write   <= d_wr;
            ex_mem_read    <= d_mr;
            ex_mem_write   <= d_mw;
            ex_illegal     <= d_ill;
            ex_branch      <= d_br;
         end else if (ex_ready) begin
            ex_valid <= 1'b0;
         end
         if (id_ready) begin
            id_valid <= if_valid;
            id_instr <= if_instr;
            id_pc    <= if_pc;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage with a queue scoreboard.
// Expected ID/EX bundles are queued at issue; a monitor pops on each consumed output.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        flush;
   logic [4:0]  rf_addr1;
   logic [4:0]  rf_addr2;
   logic [31:0] rf_data1;
   logic [31:0] rf_data2;
   logic        wb_reg_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_ready;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_op1;
   logic [31:0] ex_op2;
   logic [31:0] ex_imm;
   logic [4:0]  ex_dest;
   logic [4:0]  ex_shamt;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src_imm;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_illegal;
   logic [1:0]  ex_branch;

   id_stage dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
      .ex_dest(ex_dest), .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op),
      .ex_alu_src_imm(ex_alu_src_imm), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_illegal(ex_illegal), .ex_branch(ex_branch)
   );

   always #5 clk = ~clk;

   // Register file contents: r0 = 0, r7 = 0, others 0x100 + index
   function automatic logic [31:0] rfv(input logic [4:0] a);
      if (a == 5'd0 || a == 5'd7) return 32'h0;
      return 32'h100 + {27'h0, a};
   endfunction

   assign rf_data1 = rfv(rf_addr1);
   assign rf_data2 = rfv(rf_addr2);

   // fl = {alu_src_imm, reg_write, mem_read, mem_write, illegal}
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic [4:0]  shamt;
      logic [3:0]  alu;
      logic [4:0]  fl;
      logic [1:0]  br;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;

   function automatic exp_t mk(input logic [31:0] pc, op1, op2, imm,
                               input logic [4:0] dest, shamt,
                               input logic [3:0] alu,
                               input logic [4:0] fl,
                               input logic [1:0] br);
      exp_t e;
      e = '{pc, op1, op2, imm, dest, shamt, alu, fl, br};
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (rst_n && ex_valid && ex_ready) begin
         a = {ex_pc, ex_op1, ex_op2, ex_imm, ex_dest, ex_shamt, ex_alu_op,
              ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write,
              ex_illegal, ex_branch};
         nvec++;
         if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_out: got %h want nothing", a);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               nerr++;
               $display("FAIL out_pc%h: got %h want %h", e.pc, a, e);
            end
         end
      end
   end

   task automatic send(input logic [31:0] ins, pc, input bit push, input exp_t e);
      int n;
      if_valid = 1'b1;
      if_instr = ins;
      if_pc    = pc;
      if (push) q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!id_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!id_ready) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 if_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   localparam exp_t NONE = '0;

   initial begin
      int n;
      rst_n = 1'b0;
      if_valid = 1'b0;
      if_instr = 32'h0;
      if_pc = 32'h0;
      flush = 1'b0;
      wb_reg_write = 1'b0;
      wb_addr = 5'd0;
      wb_data = 32'h0;
      ex_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_id_ready", {31'h0, id_ready}, 32'd1);
      chk("rst_ex_valid", {31'h0, ex_valid}, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'h0);
      chk("rst_ex_rw", {31'h0, ex_reg_write}, 32'd0);
      chk("rst_ex_branch", {30'h0, ex_branch}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      send(32'h20020005, 32'h100, 1,
           mk(32'h100, 0, 32'h102, 5, 2, 0, 0, 5'b11000, 0));
      @(negedge clk);
      chk("lat_edge_n", {31'h0, ex_valid}, 32'd0);
      @(negedge clk);
      chk("lat_edge_n1", {31'h0, ex_valid}, 32'd1);
      idle(2);

      send(32'h8C230000, 32'h104, 1,
           mk(32'h104, 32'h101, 32'h103, 0, 3, 0, 0, 5'b11100, 0));
      send(32'h00652020, 32'h108, 1,
           mk(32'h108, 32'h103, 32'h105, 0, 4, 0, 0, 5'b01000, 0));
      @(negedge clk);
      chk("lu_stall_ready", {31'h0, id_ready}, 32'd0);
      @(negedge clk);
      chk("lu_bubble", {31'h0, ex_valid}, 32'd0);
      chk("lu_release", {31'h0, id_ready}, 32'd1);
      idle(1);

      wb_reg_write = 1'b1;
      wb_addr = 5'd7;
      wb_data = 32'hDEAD;
      send(32'h00E83025, 32'h10C, 1,
           mk(32'h10C, 32'hDEAD, 32'h108, 0, 6, 0, 3, 5'b01000, 0));
      idle(1);
      wb_addr = 5'd0;
      wb_data = 32'hBEEF;
      send(32'h00004820, 32'h110, 1,
           mk(32'h110, 0, 0, 0, 9, 0, 0, 5'b01000, 0));
      idle(1);
      wb_reg_write = 1'b0;

      send(32'h316A8000, 32'h114, 1,
           mk(32'h114, 32'h10B, 32'h10A, 32'h8000, 10, 0, 2, 5'b11000, 0));
      send(32'h3C0C1234, 32'h118, 1,
           mk(32'h118, 0, 32'h10C, 32'h12340000, 12, 0, 11, 5'b11000, 0));
      send(32'h000E68C0, 32'h11C, 1,
           mk(32'h11C, 0, 32'h10E, 0, 13, 3, 8, 5'b01000, 0));
      send(32'h1022FFFF, 32'h120, 1,
           mk(32'h120, 32'h101, 32'h102, 32'hFFFFFFFF, 2, 0, 1, 5'b00000, 1));
      send(32'hACC50004, 32'h124, 1,
           mk(32'h124, 32'h106, 32'h105, 4, 5, 0, 0, 5'b10010, 0));
      send(32'h20200001, 32'h128, 1,
           mk(32'h128, 32'h101, 0, 1, 0, 0, 0, 5'b10000, 0));
      idle(3);

      ex_ready = 1'b0;
      send(32'h00227826, 32'h200, 1,
           mk(32'h200, 32'h101, 32'h102, 0, 15, 0, 4, 5'b01000, 0));
      send(32'h0064802A, 32'h204, 1,
           mk(32'h204, 32'h103, 32'h104, 0, 16, 0, 6, 5'b01000, 0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_id_ready", {31'h0, id_ready}, 32'd0);
         chk("bp_ex_valid", {31'h0, ex_valid}, 32'd1);
         chk("bp_ex_pc", ex_pc, 32'h200);
         chk("bp_ex_op1", ex_op1, 32'h101);
         chk("bp_ex_dest", {27'h0, ex_dest}, 32'd15);
      end
      @(posedge clk);
      #1 ex_ready = 1'b1;
      idle(3);

      send(32'h8C230000, 32'h300, 1,
           mk(32'h300, 32'h101, 32'h103, 0, 3, 0, 0, 5'b11100, 0));
      send(32'h00652020, 32'h304, 0, NONE);
      flush = 1'b1;
      if_valid = 1'b1;
      if_instr = 32'h20020005;
      @(negedge clk);
      chk("fl_stall_ready", {31'h0, id_ready}, 32'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      if_valid = 1'b0;
      @(negedge clk);
      chk("fl_ex_valid", {31'h0, ex_valid}, 32'd0);
      chk("fl_id_empty", {31'h0, id_ready}, 32'd1);
      @(negedge clk);
      chk("fl_no_leak", {31'h0, ex_valid}, 32'd0);
      idle(1);

      send(32'h00227826, 32'h308, 0, NONE);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("fl_adv_ex_valid", {31'h0, ex_valid}, 32'd0);
      idle(1);

      send(32'hFC070000, 32'h400, 1,
           mk(32'h400, 0, 0, 0, 7, 0, 0, 5'b00001, 0));
      send(32'h0000483F, 32'h404, 1,
           mk(32'h404, 0, 0, 0, 9, 0, 0, 5'b00001, 0));
      idle(3);

      ex_ready = 1'b0;
      send(32'h00227826, 32'h500, 0, NONE);
      send(32'h0064802A, 32'h504, 0, NONE);
      @(negedge clk);
      chk("rs_stall_ready", {31'h0, id_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_ex_valid", {31'h0, ex_valid}, 32'd0);
      chk("rs_id_ready", {31'h0, id_ready}, 32'd1);
      chk("rs_ex_pc", ex_pc, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ex_ready = 1'b1;
      idle(2);
      chk("rs_after_ex_valid", {31'h0, ex_valid}, 32'd0);

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
